// File: rtl/output_classifier.sv
// Argmax classifier: captures a score vector and scans it one element per cycle.
// Define CLASSIFIER_MARGIN_EN to add the class_margin output (best minus second-best).
module output_classifier #(
    parameter  int INTEGER_WIDTH  = 8,
    parameter  int FRACTION_WIDTH = 8,
    parameter  int NUM_CLASSES    = 10,
    localparam int INDEX_WIDTH    = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     scores_ready,
    input  logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] scores [NUM_CLASSES],
    output logic [INDEX_WIDTH-1:0]                   class_index,
    output logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] class_score,
    output logic                                     class_ready,
    output logic                                     busy,
    output logic                                     overrun
`ifdef CLASSIFIER_MARGIN_EN
    ,
    output logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] class_margin
`endif
);

    localparam int W = INTEGER_WIDTH + FRACTION_WIDTH;

    typedef enum logic [0:0] {IDLE, SCAN} state_t;
    typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] score_t;

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_CLASSES - 1);

    state_t                  state_q, state_d;
    score_t                  buf_q [NUM_CLASSES];
    score_t                  buf_d [NUM_CLASSES];
    score_t                  best_value_q, best_value_d;
    logic [INDEX_WIDTH-1:0]  best_index_q, best_index_d;
    logic [INDEX_WIDTH-1:0]  counter_q, counter_d;
    logic [INDEX_WIDTH-1:0]  class_index_q, class_index_d;
    score_t                  class_score_q, class_score_d;
    logic                    class_ready_q, class_ready_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;

    score_t                  cand;
    logic                    take_new;
    score_t                  scan_best_value;
    logic [INDEX_WIDTH-1:0]  scan_best_index;

`ifdef CLASSIFIER_MARGIN_EN
    localparam score_t SCORE_MIN = {1'b1, {(W-1){1'b0}}};
    localparam score_t SCORE_MAX = {1'b0, {(W-1){1'b1}}};

    score_t second_value_q, second_value_d;
    score_t class_margin_q, class_margin_d;
    score_t scan_second_value;

    // best >= second always holds, so only the positive overflow can actually occur.
    function automatic score_t margin_of(input score_t best, input score_t second);
        logic [W:0] diff;
        diff = {best[INTEGER_WIDTH-1], best} - {second[INTEGER_WIDTH-1], second};
        if (diff[W] != diff[W-1]) begin
            return diff[W] ? SCORE_MIN : SCORE_MAX;
        end
        return diff[W-1:0];
    endfunction
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        buf_d         = buf_q;
        best_value_d  = best_value_q;
        best_index_d  = best_index_q;
        counter_d     = counter_q;
        class_index_d = class_index_q;
        class_score_d = class_score_q;
        class_ready_d = 1'b0;
        overrun_d     = 1'b0;

        cand            = buf_q[counter_q];
        take_new        = cand > best_value_q;
        scan_best_value = take_new ? cand : best_value_q;
        scan_best_index = take_new ? counter_q : best_index_q;
`ifdef CLASSIFIER_MARGIN_EN
        second_value_d = second_value_q;
        class_margin_d = class_margin_q;
        // Equal values count as second-best, so a tie with the leader gives margin 0.
        if (take_new) begin
            scan_second_value = best_value_q;
        end else if (cand >= second_value_q) begin
            scan_second_value = cand;
        end else begin
            scan_second_value = second_value_q;
        end
`endif

        case (state_q)
            IDLE: begin
                if (scores_ready) begin
                    buf_d        = scores;
                    best_value_d = scores[0];
                    best_index_d = '0;
                    counter_d    = INDEX_WIDTH'(1);
`ifdef CLASSIFIER_MARGIN_EN
                    second_value_d = SCORE_MIN;
`endif
                    if (NUM_CLASSES == 1) begin
                        class_index_d = '0;
                        class_score_d = scores[0];
                        class_ready_d = 1'b1;
`ifdef CLASSIFIER_MARGIN_EN
                        class_margin_d = SCORE_MAX;
`endif
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                overrun_d    = scores_ready;
                best_value_d = scan_best_value;
                best_index_d = scan_best_index;
                counter_d    = counter_q + INDEX_WIDTH'(1);
`ifdef CLASSIFIER_MARGIN_EN
                second_value_d = scan_second_value;
`endif
                if (counter_q == LAST_INDEX) begin
                    state_d       = IDLE;
                    class_index_d = scan_best_index;
                    class_score_d = scan_best_value;
                    class_ready_d = 1'b1;
`ifdef CLASSIFIER_MARGIN_EN
                    class_margin_d = margin_of(scan_best_value, scan_second_value);
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SCAN);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            // NOTE: the score buffer is explicitly cleared on reset, so it is built from flops rather than RAM.
            for (int i = 0; i < NUM_CLASSES; i++) begin
                buf_q[i] <= '0;
            end
            best_value_q  <= '0;
            best_index_q  <= '0;
            counter_q     <= '0;
            class_index_q <= '0;
            class_score_q <= '0;
            class_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef CLASSIFIER_MARGIN_EN
            second_value_q <= '0;
            class_margin_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            best_value_q  <= best_value_d;
            best_index_q  <= best_index_d;
            counter_q     <= counter_d;
            class_index_q <= class_index_d;
            class_score_q <= class_score_d;
            class_ready_q <= class_ready_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
`ifdef CLASSIFIER_MARGIN_EN
            second_value_q <= second_value_d;
            class_margin_q <= class_margin_d;
`endif
        end
    end

    assign class_index = class_index_q;
    assign class_score = class_score_q;
    assign class_ready = class_ready_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
`ifdef CLASSIFIER_MARGIN_EN
    assign class_margin = class_margin_q;
`endif

endmodule

// File: tb/tb_output_classifier.sv
// Scoreboard bench for output_classifier: stimulus queues expected results, a negedge monitor checks them.
// Margin checks are compiled in when CLASSIFIER_MARGIN_EN is defined.
module tb_output_classifier;

    localparam int N = 10;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                scores_ready = 1'b0;
    logic signed [7:-8]  scores [N];
    logic [3:0]          class_index;
    logic signed [7:-8]  class_score;
    logic                class_ready;
    logic                busy;
    logic                overrun;
`ifdef CLASSIFIER_MARGIN_EN
    logic signed [7:-8]  class_margin;
`endif

    output_classifier #(
        .INTEGER_WIDTH (8),
        .FRACTION_WIDTH(8),
        .NUM_CLASSES   (N)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .scores_ready(scores_ready),
        .scores      (scores),
        .class_index (class_index),
        .class_score (class_score),
        .class_ready (class_ready),
        .busy        (busy),
        .overrun     (overrun)
`ifdef CLASSIFIER_MARGIN_EN
        ,
        .class_margin(class_margin)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [3:0]  idx;
        logic [15:0] score;
        logic [15:0] margin;
    } exp_t;

    exp_t        res_q[$];
    int          ov_q[$];
    int          busy_lo = -1;
    int          busy_hi = -1;
    logic [3:0]  held_idx = '0;
    logic [15:0] held_score = '0;
    logic [15:0] held_margin = '0;
    logic [15:0] vec [N];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_all(input logic [15:0] v);
        foreach (vec[i]) vec[i] = v;
    endtask

    // Drive vec for one cycle; queue the result if it should be accepted, else an overrun.
    task automatic issue(input bit accepted, input logic [3:0] idx,
                         input logic [15:0] sc, input logic [15:0] mg);
        int   c;
        exp_t e;
        c = cyc;
        foreach (scores[i]) scores[i] = vec[i];
        scores_ready = 1'b1;
        if (accepted) begin
            e.cyc    = c + N;
            e.idx    = idx;
            e.score  = sc;
            e.margin = mg;
            res_q.push_back(e);
            busy_lo = c + 1;
            busy_hi = c + N - 1;
        end else begin
            ov_q.push_back(c + 1);
        end
        @(posedge clock);
        #1;
        scores_ready = 1'b0;
        foreach (scores[i]) scores[i] = 16'($urandom);
    endtask

    always @(negedge clock) begin
        bit   exp_rdy;
        bit   exp_ov;
        exp_t e;
        if (!reset) begin
            check("rst_class_ready", 32'(class_ready), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_overrun", 32'(overrun), 32'd0);
            check("rst_class_index", 32'(class_index), 32'd0);
            check("rst_class_score", 32'($unsigned(class_score)), 32'd0);
`ifdef CLASSIFIER_MARGIN_EN
            check("rst_class_margin", 32'($unsigned(class_margin)), 32'd0);
`endif
        end else begin
            check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));

            exp_ov = (ov_q.size() > 0) && (ov_q[0] == cyc);
            check("overrun", 32'(overrun), 32'(exp_ov));
            if (exp_ov) void'(ov_q.pop_front());

            exp_rdy = (res_q.size() > 0) && (res_q[0].cyc == cyc);
            check("class_ready", 32'(class_ready), 32'(exp_rdy));
            if (exp_rdy) begin
                e = res_q.pop_front();
                held_idx    = e.idx;
                held_score  = e.score;
                held_margin = e.margin;
            end
            check("class_index", 32'(class_index), 32'(held_idx));
            check("class_score", 32'($unsigned(class_score)), 32'(held_score));
`ifdef CLASSIFIER_MARGIN_EN
            check("class_margin", 32'($unsigned(class_margin)), 32'(held_margin));
`endif
        end
    end

    initial begin
        int b;
        foreach (scores[i]) scores[i] = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;

        // Single maximum at index 7
        b = cyc;
        set_all(16'h0000); vec[7] = 16'h0180;
        goto(b + 5); issue(1'b1, 4'd7, 16'h0180, 16'h0180);
        goto(b + 18);

        // Tie keeps the lower index
        b = cyc;
        set_all(16'hFF00); vec[2] = 16'h0200; vec[6] = 16'h0200;
        goto(b + 1); issue(1'b1, 4'd2, 16'h0200, 16'h0000);
        goto(b + 14);

        // All most-negative
        b = cyc;
        set_all(16'h8000);
        goto(b + 1); issue(1'b1, 4'd0, 16'h8000, 16'h0000);
        goto(b + 14);

        // Margin saturation
        b = cyc;
        set_all(16'h8000); vec[0] = 16'h7F00;
        goto(b + 1); issue(1'b1, 4'd0, 16'h7F00, 16'h7FFF);
        goto(b + 14);

        // Strobe mid-scan is dropped and flagged
        b = cyc;
        set_all(16'h0000); vec[7] = 16'h0180;
        goto(b + 5); issue(1'b1, 4'd7, 16'h0180, 16'h0180);
        set_all(16'h0000); vec[3] = 16'h7FFF;
        goto(b + 8); issue(1'b0, 4'd0, 16'h0000, 16'h0000);
        goto(b + 30);

        // Back-to-back: strobe coincident with class_ready
        b = cyc;
        set_all(16'h0010); vec[4] = 16'h0300;
        goto(b + 5); issue(1'b1, 4'd4, 16'h0300, 16'h02F0);
        set_all(16'h0080); vec[9] = 16'h0100;
        goto(b + 15); issue(1'b1, 4'd9, 16'h0100, 16'h0080);
        goto(b + 30);

        // Reset mid-scan discards the scan
        b = cyc;
        set_all(16'h0000); vec[3] = 16'h0040;
        goto(b + 5); issue(1'b1, 4'd3, 16'h0040, 16'h0040);
        goto(b + 10);
        reset = 1'b0;
        res_q.delete();
        busy_lo = -1;
        busy_hi = -1;
        held_idx = '0;
        held_score = '0;
        held_margin = '0;
        goto(b + 12);
        reset = 1'b1;
        set_all(16'hFFFF); vec[5] = 16'h0050;
        goto(b + 14); issue(1'b1, 4'd5, 16'h0050, 16'h0051);
        goto(b + 30);

        check("results_pending", 32'(res_q.size()), 32'd0);
        check("overruns_pending", 32'(ov_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_classifier.md
Name: output_classifier

Overview:
- Sits directly downstream of neural_network and consumes its final-layer score vector and its outputs_ready strobe.
- Captures the vector, then scans it sequentially, one comparison per cycle, to find the index of the largest score (argmax).
- Presents the predicted class index, its score and a one-cycle class_ready strobe to the display/UART reporting logic.

Parameters:
NUM_CLASSES, 10, number of scores (equals the final layer SIZE); legal range 1..256
INDEX_WIDTH, $clog2(NUM_CLASSES) (minimum 1), width of class_index; derived, never overridden

Ports:
clock  input  1  system clock; all logic on the rising edge
reset  input  1  asynchronous, active-low reset
scores_ready  input  1  single-cycle strobe: scores valid this cycle (driven from neural_network outputs_ready)
scores  input  NUM_CLASSES x [INTEGER_WIDTH-1:-FRACTION_WIDTH] signed  score vector, valid only while scores_ready is high
class_index  output  INDEX_WIDTH  index of the maximum score; held until the next result
class_score  output  [INTEGER_WIDTH-1:-FRACTION_WIDTH] signed  value of the maximum score; held
class_ready  output  1  one-cycle strobe: class_index/class_score just updated
busy  output  1  high while a scan is in progress
overrun  output  1  one-cycle strobe: scores_ready arrived while busy and was dropped

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset low, any time, including mid-scan):
  - state=IDLE; class_index=0, class_score=0, class_ready=0, busy=0, overrun=0.
  - Internal score buffer, best register and counter cleared; an in-flight scan is discarded with no class_ready.
- States: IDLE, SCAN.
- IDLE, scores_ready high:
  - Register all NUM_CLASSES scores into a local buffer.
  - best_value=scores[0], best_index=0, counter=1.
  - If NUM_CLASSES=1: publish results at this edge and stay IDLE.
  - Otherwise: go to SCAN; busy=1 from the next cycle.
- SCAN, each cycle: compare buffer[counter] with best_value (signed). Replace only if strictly greater, so ties keep the lowest index. Then counter++.
- SCAN, the cycle counter=NUM_CLASSES-1: after the final comparison, at the same edge:
  - register class_index/class_score from the final best;
  - class_ready=1 for exactly one cycle;
  - busy=0; state returns to IDLE.
- Latency: scores_ready high in cycle k gives class_ready high in cycle k+NUM_CLASSES. Throughput is one vector per NUM_CLASSES cycles.
- Back-to-back: scores_ready in the same cycle class_ready is high is accepted (state is already IDLE).
- scores_ready while in SCAN:
  - vector dropped; the current scan continues unaffected;
  - overrun=1 for the next cycle only;
  - the buffer is not overwritten.
- class_index and class_score change only on a class_ready edge or reset. Between results they hold their last values.
- Arithmetic:
  - Comparisons are full-width signed; no rounding or scaling.
  - Most negative score (0x8000 in Q8.8) is a legal maximum if all scores are equal to it: index 0 is reported.
- The scores port is never sampled outside the acceptance cycle, so upstream may change it freely afterwards.

Optional Feature:
- Macro: CLASSIFIER_MARGIN_EN
- Defined:
  - Adds output class_margin, signed [INTEGER_WIDTH-1:-FRACTION_WIDTH], = best minus second-best score.
  - Also tracked during the scan: second_value, initialised to the most negative value. On a new best, second=old best. Otherwise, if new > second, second=new. Equal values count as second, so a tie gives margin 0.
  - Subtraction is computed one bit wider and saturated to the maximum positive value.
  - NUM_CLASSES=1 gives the maximum positive value.
  - Registered and held alongside class_score; reset value 0.
- Undefined: port and second-best logic absent; all other behaviour identical.

Test Plan (bench: INTEGER_WIDTH=8, FRACTION_WIDTH=8, NUM_CLASSES=10):
1. Scores all 0x0000 except scores[7]=0x0180, strobe in cycle 5:
   - class_ready high in cycle 15 only;
   - class_index=7, class_score=0x0180;
   - busy high cycles 6-14.
2. Tie: scores[2]=scores[6]=0x0200, others 0xFF00 -> class_index=2. With CLASSIFIER_MARGIN_EN: class_margin=0x0000.
3. All scores 0x8000 -> class_index=0, class_score=0x8000. Margin case: scores[0]=0x7F00, others 0x8000 -> class_margin saturates to 0x7FFF.
4. Second strobe in cycle 8 (mid-scan of strobe at cycle 5):
   - overrun high in cycle 9;
   - cycle-15 result reflects the first vector only;
   - no second class_ready.
5. Second strobe in cycle 15, coincident with class_ready:
   - accepted;
   - next class_ready in cycle 25 with the new vector's argmax (scores[9]=0x0100 max -> index 9).
6. reset low in cycle 10 mid-scan, released cycle 12:
   - all outputs 0 immediately;
   - no class_ready;
   - a new strobe in cycle 14 gives correct class_ready in cycle 24.
